param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
- Parametrised single-clock synchronous FIFO for buffering words between the FPGA link transmitter/receiver and local logic.
- Successor to the fixed 16x16 FIFO, with these changes:
  - Width and depth are configurable.
  - Read and write can happen in the same cycle.
  - Adds occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, error pulses and a synchronous flush.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (>=1).
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents and pointers.
- write_en  in  1  write request.
- data_in  in  WIDTH  write data.
- read_en  in  1  read request.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe: data_out updated this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write_en while full and no read accepted in that cycle.
- underflow  out  1  one-cycle pulse: read_en while empty.

Behaviour:
- Reset:
  - reset_n low asynchronously clears the read and write pointers (each DEPTH_LOG2+1 bits, wrap bit in the MSB), count, data_out, data_valid, overflow and underflow to 0.
  - Flag values during reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
  - Release of reset is taken on the next clk edge.
- Accept rules, evaluated on the registered state before the edge:
  - rd_ok = read_en && !empty.
  - wr_ok = write_en && (!full || rd_ok).
- Write: on wr_ok, mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in and wr_ptr increments.
- Read:
  - On rd_ok, data_out <= mem[rd_ptr[DEPTH_LOG2-1:0]], rd_ptr increments and data_valid=1 in the following cycle.
  - Read latency is 1 clock (not first-word-fall-through).
  - data_out holds its value when no read is accepted.
- Simultaneous read and write:
  - Both are accepted in the same cycle; count is unchanged.
  - When empty: only the write is accepted and underflow pulses.
  - When full: both are accepted (write into the slot freed by the read); no overflow.
- Count: count_next = count + wr_ok - rd_ok. All flags are combinational decodes of the registered count and pointers.
- Full/empty decode: full = pointer indices equal with wrap bits different; empty = pointers identical. Must match count at all times.
- Wrap-around: pointers roll over modulo 2*DEPTH naturally; no special case.
- Error pulses: overflow and underflow are registered, high for exactly one cycle per offending request; FIFO state is unchanged by the rejected part of the request.
- Flush:
  - Priority over read/write in the same cycle: pointers and count go to 0, data_valid goes to 0, data_out holds, no error pulses.
  - A read/write presented together with flush is dropped.
- Parameter check: AF_LEVEL/AE_LEVEL out of range is an elaboration error (assertion).

Decomposition:
- Package fifo_pkg:
  - Function clog2.
  - Typedef for the pointer (DEPTH_LOG2+1 bits).
  - Localparam defaults (WIDTH=16, DEPTH_LOG2=4).
- Sub-module fifo_ram: simple dual-port RAM with one write port and one registered read port, so it maps to distributed or block RAM.
- param_sync_fifo holds the pointers, count, flags and the control logic.

Test Plan (WIDTH=16, DEPTH_LOG2=4, AF_LEVEL=14, AE_LEVEL=2):
- Reset and fill:
  - Stimulus: pull reset_n low mid-stream after 5 writes, then release; then write 0x0001..0x0010 over 16 cycles.
  - Required: count=0 and empty=1 immediately on the reset assertion; after the fills, almost_full at count=14, full=1 at count=16.
  - Required: a 17th write (0xDEAD) gives overflow=1 for one cycle and count stays 16.
- Drain order:
  - Stimulus: from full, read_en for 16 cycles.
  - Required: data_out = 0x0001..0x0010 with data_valid one cycle after each read; almost_empty at count=2; empty at the end.
  - Required: one further read gives underflow=1 and data_out holds 0x0010.
- Simultaneous at full:
  - Stimulus: at count=16, read_en=1 and write_en=1 with data 0x0BEE.
  - Required: data_out=0x0001, count stays 16, no overflow; 0x0BEE is read out 16 reads later.
- Simultaneous at empty:
  - Stimulus: at count=0, read_en=1 and write_en=1 with data 0x1234.
  - Required: underflow pulse, count=1, next read returns 0x1234.
- Wrap-around:
  - Stimulus: 40 cycles of continuous write+read after preloading 3 words.
  - Required: count stays 3, output sequence in order, pointers wrap with no glitch on full/empty.
- Flush:
  - Stimulus: at count=7, assert flush together with write_en=1.
  - Required: next cycle count=0, empty=1; the write is dropped; data_out unchanged.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
//   FIFO_WIDTH_DEF      default data word width
//   FIFO_DEPTH_LOG2_DEF default log2 of the entry count
//   fifo_ptr_t          read/write pointer at the default depth (index + wrap bit)
//   clog2()             ceiling log2, usable in constant expressions
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF      = 16;
  localparam int FIFO_DEPTH_LOG2_DEF = 4;

  typedef logic [FIFO_DEPTH_LOG2_DEF:0] fifo_ptr_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one read port with a
// registered output so it maps onto distributed or block RAM.
// Ports:
//   clk      rising-edge clock
//   reset_n  async active-low reset, clears only the read output register
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data holds when low
//   rd_addr  read address
//   rd_data  registered read data
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH_DEF,
  parameter int ADDR_W = FIFO_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // No reset on the array so it stays inferable as RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-address read and write return the old word: the slot being read
  // is the one the write is refilling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO between the link transmitter/receiver and
// local logic. One-cycle read latency, simultaneous read/write, occupancy
// count, programmable almost flags, error pulses and synchronous flush.
// Ports:
//   clk           rising-edge clock
//   reset_n       async active-low reset
//   flush         synchronous clear; drops any read/write in the same cycle
//   write_en      write request
//   data_in       write data
//   read_en       read request
//   data_out      registered read data, holds when no read is accepted
//   data_valid    data_out was updated by a read this cycle
//   full, empty   occupancy == DEPTH / == 0 (pointer decode)
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      pulse: write rejected because full
//   underflow     pulse: read rejected because empty
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH_DEF,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
  parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  write_en,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  read_en,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0] ptr_t;
  typedef logic [DEPTH_LOG2:0] cnt_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t AF_CNT   = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_CNT   = cnt_t'(AE_LEVEL);

  if (DEPTH_LOG2 < 1 || clog2(DEPTH) != DEPTH_LOG2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH_LOG2 must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH must be >= 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must be within 0..DEPTH-1");
  end

  ptr_t wr_ptr, rd_ptr;
  cnt_t count_next;
  logic rd_ok, wr_ok, rd_acc, wr_acc;

  // Flags decode the registered pointers/count only.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                        (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A write at full is still taken when a read frees a slot in the same cycle.
  assign rd_ok  = read_en && !empty;
  assign wr_ok  = write_en && (!full || rd_ok);
  assign rd_acc = rd_ok && !flush;
  assign wr_acc = wr_ok && !flush;

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_next;
      data_valid <= rd_acc;
      overflow   <= write_en && full && !rd_ok;
      underflow  <= read_en && empty;
    end
  end

  fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (data_out)
  );

  // Pointer-derived flags and the occupancy counter must never disagree.
  a_flags_match_count : assert property (@(posedge clk) disable iff (!reset_n)
    (full == (count == CNT_FULL)) && (empty == (count == '0)));

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int W     = 16;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           flush = 1'b0;
  logic           write_en = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           read_en = 1'b0;
  logic [W-1:0]   data_out;
  logic           data_valid, full, empty, almost_full, almost_empty;
  logic [DL2:0]   count;
  logic           overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the last value handed out.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  bit           m_valid = 0, m_ovf = 0, m_udf = 0;

  param_sync_fifo #(.WIDTH(W), .DEPTH_LOG2(DL2), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .write_en     (write_en),
    .data_in      (data_in),
    .read_en      (read_en),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit f, input logic [W-1:0] d);
    bit rd, wr;
    if (f) begin
      mq.delete();
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rd = r && (mq.size() > 0);
      wr = w && ((mq.size() < DEPTH) || rd);
      m_udf   = r && (mq.size() == 0);
      m_ovf   = w && (mq.size() == DEPTH) && !rd;
      m_valid = rd;
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(d);
    end
  endtask

  // Inputs change on the falling edge; the DUT samples on the rising edge;
  // outputs are checked on the following falling edge.
  task automatic cycle(input bit w, input bit r, input bit f, input logic [W-1:0] d);
    write_en = w; read_en = r; flush = f; data_in = d;
    @(posedge clk);
    model_step(w, r, f, d);
    @(negedge clk);
    write_en = 0; read_en = 0; flush = 0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},        count,        n);
    chk({tag, ".full"},         full,         (n == DEPTH));
    chk({tag, ".empty"},        empty,        (n == 0));
    chk({tag, ".almost_full"},  almost_full,  (n >= AF));
    chk({tag, ".almost_empty"}, almost_empty, (n <= AE));
    chk({tag, ".data_out"},     data_out,     m_dout);
    chk({tag, ".data_valid"},   data_valid,   m_valid);
    chk({tag, ".overflow"},     overflow,     m_ovf);
    chk({tag, ".underflow"},    underflow,    m_udf);
  endtask

  typedef struct {
    bit           w, r, f;
    logic [W-1:0] d;
    int           e_count;
    logic [W-1:0] e_dout;
    bit           e_valid, e_ovf, e_udf, e_empty;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int wprob;
    bit rw, rr, rf;
    logic [W-1:0] hold;

    //        w  r  f  data     cnt dout     vld ovf udf emp
    vecs[0] = '{1, 0, 0, 16'h00A1, 1, 16'h0000, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 16'h00B2, 2, 16'h0000, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 16'h0000, 1, 16'h00A1, 1, 0, 0, 0};
    vecs[3] = '{1, 1, 0, 16'h00C3, 1, 16'h00B2, 1, 0, 0, 0};
    vecs[4] = '{0, 1, 0, 16'h0000, 0, 16'h00C3, 1, 0, 0, 1};
    vecs[5] = '{0, 1, 0, 16'h0000, 0, 16'h00C3, 0, 0, 1, 1};
    vecs[6] = '{1, 1, 0, 16'h00D4, 1, 16'h00C3, 0, 0, 1, 0};
    vecs[7] = '{1, 0, 1, 16'h00E5, 0, 16'h00C3, 0, 0, 0, 1};
    vecs[8] = '{0, 1, 0, 16'h0000, 0, 16'h00C3, 0, 0, 1, 1};
    vecs[9] = '{0, 0, 0, 16'h0000, 0, 16'h00C3, 0, 0, 0, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.almost_empty", almost_empty, 1);
    chk("rst.almost_full", almost_full, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.data_valid", data_valid, 0);
    chk("rst.overflow", overflow, 0);
    chk("rst.underflow", underflow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Hand-computed short sequence
    foreach (vecs[i]) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].d);
      chk($sformatf("vec%0d.count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d.data_out", i), data_out, vecs[i].e_dout);
      chk($sformatf("vec%0d.data_valid", i), data_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d.overflow", i), overflow, vecs[i].e_ovf);
      chk($sformatf("vec%0d.underflow", i), underflow, vecs[i].e_udf);
      chk($sformatf("vec%0d.empty", i), empty, vecs[i].e_empty);
    end

    // Reset mid-stream: takes effect without a clock edge
    for (int i = 1; i <= 5; i++) cycle(1, 0, 0, 16'h0100 + 16'(i));
    chk("mid.count_pre", count, 5);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.count", count, 0);
    chk("midrst.empty", empty, 1);
    chk("midrst.data_out", data_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_all("after_rst");

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 0, 16'(i));
      check_all("fill");
      if (i == 13) chk("fill.af_below", almost_full, 0);
      if (i == 14) chk("fill.af_at14", almost_full, 1);
      if (i == 15) chk("fill.full_at15", full, 0);
      if (i == 16) chk("fill.full_at16", full, 1);
    end
    cycle(1, 0, 0, 16'hDEAD);
    chk("ovf.pulse", overflow, 1);
    chk("ovf.count", count, 16);
    cycle(0, 0, 0, '0);
    chk("ovf.one_cycle", overflow, 0);

    // Drain order
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, '0);
      check_all("drain");
      chk("drain.data", data_out, 16'(i));
      chk("drain.valid", data_valid, 1);
      if (i == 14) chk("drain.ae_at2", almost_empty, 1);
      if (i == 13) chk("drain.ae_at3", almost_empty, 0);
    end
    chk("drain.empty", empty, 1);
    cycle(0, 1, 0, '0);
    chk("udf.pulse", underflow, 1);
    chk("udf.hold", data_out, 16'h0010);
    chk("udf.valid", data_valid, 0);
    cycle(0, 0, 0, '0);
    chk("udf.one_cycle", underflow, 0);

    // Simultaneous read/write at full
    for (int i = 1; i <= 16; i++) cycle(1, 0, 0, 16'(i));
    cycle(1, 1, 0, 16'h0BEE);
    check_all("simfull");
    chk("simfull.data", data_out, 16'h0001);
    chk("simfull.count", count, 16);
    chk("simfull.ovf", overflow, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, '0);
      check_all("simfull_drain");
    end
    chk("simfull.bee_last", data_out, 16'h0BEE);

    // Simultaneous read/write at empty
    cycle(1, 1, 0, 16'h1234);
    check_all("simempty");
    chk("simempty.udf", underflow, 1);
    chk("simempty.count", count, 1);
    cycle(0, 1, 0, '0);
    chk("simempty.read", data_out, 16'h1234);

    // Wrap-around with constant occupancy of 3
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h2000 + 16'(i));
    for (int i = 3; i < 43; i++) begin
      cycle(1, 1, 0, 16'h2000 + 16'(i));
      check_all("wrap");
      chk("wrap.data", data_out, 16'h2000 + 16'(i - 3));
    end

    // Flush at count 7 with a concurrent write
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 16'h3000 + 16'(i));
    chk("flush.pre_count", count, 7);
    hold = data_out;
    cycle(1, 0, 1, 16'h7777);
    check_all("flush");
    chk("flush.count", count, 0);
    chk("flush.empty", empty, 1);
    chk("flush.hold", data_out, hold);
    cycle(0, 1, 0, '0);
    chk("flush.dropped_write", underflow, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wprob = ((i / 200) % 2 == 0) ? 70 : 30;
      rw = ($urandom_range(0, 99) < wprob);
      rr = ($urandom_range(0, 99) < (100 - wprob));
      rf = ($urandom_range(0, 199) == 0);
      cycle(rw, rr, rf, W'($urandom));
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
